// File: rtl/seg7_trace_display.sv
// seg7_trace_display: shows the computer's pc or inst as 8 hex digits on a
// time-multiplexed common-anode 7-segment display (active-low seg/an).
// A debounced button toggles the view; freeze holds the current image.
// The image is captured once per frame so that a frame never tears.
// Optional build macro SEG7_PC_REL_EN: PC view shows pc - 0x00400000.
module seg7_trace_display #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        sel_btn,
  input  logic        freeze,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        view
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       digit;
  logic [31:0]      snapshot;
  logic             snap_view;
  logic             sync1, sync2;
  logic             db_level;
  logic [DB_W-1:0]  db_cnt;

  logic        capture;
  logic [31:0] pc_val;
  logic [31:0] disp_val;
  logic        disp_view;
  logic [3:0]  nibble;
  logic [6:0]  hex_seg;
  logic        db_done;
  logic        db_rise;

  // PC value as seen by the display (raw or IMEM-relative)
  always_comb begin
`ifdef SEG7_PC_REL_EN
    pc_val = pc - 32'h0040_0000;
`else
    pc_val = pc;
`endif
  end

  // Frame-start capture bypass: the capturing edge already shows the new image
  always_comb begin
    capture   = (div == '0) && (digit == 3'd0) && !freeze;
    disp_val  = snapshot;
    disp_view = snap_view;
    if (capture) begin
      disp_val  = view ? inst : pc_val;
      disp_view = view;
    end
    nibble = disp_val[{digit, 2'b00} +: 4];
  end

  // Hex to segment decode, bits g..a, active-low
  always_comb begin
    hex_seg = 7'b1111111;
    case (nibble)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  end

  // Scan counter: div paces the digit, digit wraps 7 -> 0
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div   <= '0;
      digit <= 3'd0;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      digit <= digit + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Snapshot of the displayed value, refreshed only at an unfrozen frame start
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      snapshot  <= '0;
      snap_view <= 1'b0;
    end else if (capture) begin
      snapshot  <= disp_val;
      snap_view <= disp_view;
    end
  end

  // Registered pin drive; dp on the rightmost digit marks instruction view
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      an_n  <= 8'hFF;
      seg_n <= 8'hFF;
    end else begin
      an_n  <= ~(8'b1 << digit);
      seg_n <= {~((digit == 3'd0) && disp_view), hex_seg};
    end
  end

  assign db_done = (sync2 != db_level) && (db_cnt == DB_LAST);
  assign db_rise = db_done && sync2;

  // Button synchroniser and debouncer; any equal sample restarts the count
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= sel_btn;
      sync2 <= sync1;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // View toggles on each debounced press (release is ignored)
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      view <= 1'b0;
    end else if (db_rise) begin
      view <= ~view;
    end
  end

endmodule

// File: tb/tb_seg7_trace_display.sv
// Directed bench for seg7_trace_display with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// Expected pin values are pushed to a queue before each edge and popped after.
module tb_seg7_trace_display;

  localparam int SD    = 4;
  localparam int DB    = 8;
  localparam int FRAME = 8 * SD;

  logic        clk_in;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        sel_btn;
  logic        freeze;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;
  logic        view;

  int          checks;
  int          errors;
  int          cyc;
  logic [31:0] mdl_snap;
  logic        mdl_sview;
  logic        mdl_view;
  logic [15:0] q[$];

  seg7_trace_display #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .pc     (pc),
    .inst   (inst),
    .sel_btn(sel_btn),
    .freeze (freeze),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .view   (view)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] pc_adj(input logic [31:0] p);
`ifdef SEG7_PC_REL_EN
    return p - 32'h0040_0000;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // one clock: predict pins from the bench's frame model, then compare
  task automatic tick();
    int pos;
    int dig;
    logic [3:0]  nib;
    logic [7:0]  ean;
    logic [7:0]  eseg;
    logic [15:0] e;
    pos = cyc % FRAME;
    dig = pos / SD;
    if (pos == 0 && !freeze) begin
      mdl_snap  = mdl_view ? inst : pc_adj(pc);
      mdl_sview = mdl_view;
    end
    nib  = 4'((mdl_snap >> (4 * dig)) & 32'hF);
    ean  = ~(8'b1 << dig);
    eseg = {~(dig == 0 && mdl_sview), hex7(nib)};
    q.push_back({ean, eseg});
    @(posedge clk_in);
    #1;
    cyc++;
    e = q.pop_front();
    check("pins", {16'h0, an_n, seg_n}, {16'h0, e});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (cyc % FRAME) != pos; i++) tick();
  endtask

  task automatic model_reset();
    cyc       = 0;
    mdl_snap  = '0;
    mdl_sview = 1'b0;
    mdl_view  = 1'b0;
    q.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    pc      = 32'h0040_0010;
    inst    = 32'h0000_0000;
    sel_btn = 1'b0;
    freeze  = 1'b0;
    model_reset();

    // reset state
    #12;
    check("rst_an", {24'h0, an_n}, 32'hFF);
    check("rst_seg", {24'h0, seg_n}, 32'hFF);
    check("rst_view", {31'h0, view}, 32'h0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;

    // first frames after reset release
    tick();
    check("edge1_an", {24'h0, an_n}, 32'hFE);
    check("edge1_seg", {24'h0, seg_n}, 32'hC0);
    ticks(4);
    check("edge5_an", {24'h0, an_n}, 32'hFD);
    check("edge5_seg", {24'h0, seg_n}, 32'hF9);
    ticks(2 * FRAME - 5);

    // bouncing button never settles
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) sel_btn = ~sel_btn;
      tick();
    end
    sel_btn = 1'b0;
    ticks(12);
    check("bounce_view", {31'h0, view}, 32'h0);

    // pc change mid-frame waits for the next frame start
    run_to(3 * SD);
    pc = 32'h0040_ABC0;
    run_to(0);
    ticks(FRAME);

    // freeze mid-frame holds the old snapshot
    run_to(10);
    freeze = 1'b1;
    pc     = 32'h0040_0020;
    ticks(2 * FRAME);
    run_to(10);
    freeze = 1'b0;
    run_to(0);
    ticks(FRAME);

    // clean press toggles view 2+DB cycles later
    inst    = 32'h8C1F_0004;
    sel_btn = 1'b1;
    ticks(9);
    check("press_view_early", {31'h0, view}, 32'h0);
    tick();
    check("press_view", {31'h0, view}, 32'h1);
    mdl_view = 1'b1;
    ticks(10);
    sel_btn = 1'b0;
    ticks(12);
    check("release_view", {31'h0, view}, 32'h1);
    run_to(0);
    tick();
    check("inst_dig0_seg", {24'h0, seg_n}, 32'h19);
    ticks(FRAME - 1);

    // asynchronous reset mid-frame at digit 5
    run_to(5 * SD + 2);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_an", {24'h0, an_n}, 32'hFF);
    check("midrst_seg", {24'h0, seg_n}, 32'hFF);
    check("midrst_view", {31'h0, view}, 32'h0);
    @(posedge clk_in);
    #1;
    check("midrst_hold_an", {24'h0, an_n}, 32'hFF);
    reset = 1'b0;
    model_reset();
    tick();
    check("postrst_an", {24'h0, an_n}, 32'hFE);
    ticks(FRAME - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
